// File: rtl/vote_tally_if.sv
// Bundle of the vote_tally control and status signals; the voting panel drives
// master, vote_tally is slave. total_count exists only when TOTAL_COUNT_EN is defined.
interface vote_tally_if #(
  parameter int COUNT_W = 8
);
  logic               mode;
  logic [3:0]         vote_in;
  logic [1:0]         disp_sel;
  logic [COUNT_W-1:0] vote_count;
  logic [3:0]         leds;
  logic               busy;
  logic               invalid_vote;
`ifdef TOTAL_COUNT_EN
  logic [COUNT_W+1:0] total_count;

  modport master (output mode, vote_in, disp_sel,
                  input  vote_count, leds, busy, invalid_vote, total_count);
  modport slave  (input  mode, vote_in, disp_sel,
                  output vote_count, leds, busy, invalid_vote, total_count);
`else
  modport master (output mode, vote_in, disp_sel,
                  input  vote_count, leds, busy, invalid_vote);
  modport slave  (input  mode, vote_in, disp_sel,
                  output vote_count, leds, busy, invalid_vote);
`endif
endinterface

// File: rtl/vote_tally.sv
// Four-candidate vote tally with post-vote lockout and a display mode.
// Optional macro TOTAL_COUNT_EN adds a registered total_count of all tallies.
module vote_tally #(
  parameter int COUNT_W        = 8,
  parameter int LOCKOUT_CYCLES = 100000000
) (
  input  logic        clock,
  input  logic        reset,
  vote_tally_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK    = 2'd1,
    DISPLAY = 2'd2
  } state_t;

  localparam logic [31:0]        LOCK_LAST = 32'(LOCKOUT_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ZERO  = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);

  function automatic logic [2:0] vote_weight(input logic [3:0] v);
    vote_weight = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [1:0] vote_index(input logic [3:0] v);
    case (v)
      4'b0001: vote_index = 2'd0;
      4'b0010: vote_index = 2'd1;
      4'b0100: vote_index = 2'd2;
      4'b1000: vote_index = 2'd3;
      default: vote_index = 2'd0;
    endcase
  endfunction

  state_t             state_r;
  logic [31:0]        lock_cnt_r;
  logic [COUNT_W-1:0] tally_r [4];
  logic [COUNT_W-1:0] vote_count_r;
  logic [3:0]         leds_r;
  logic               busy_r;
  logic               invalid_r;
  logic [2:0]         weight_s;
  logic [1:0]         index_s;

  assign weight_s = vote_weight(bus.vote_in);
  assign index_s  = vote_index(bus.vote_in);

  // Voting FSM: tallies, lockout timer and all registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      lock_cnt_r   <= 32'd0;
      vote_count_r <= CNT_ZERO;
      leds_r       <= 4'b0000;
      busy_r       <= 1'b0;
      invalid_r    <= 1'b0;
      for (int i = 0; i < 4; i++) tally_r[i] <= CNT_ZERO;
    end else begin
      invalid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          vote_count_r <= CNT_ZERO;
          if (bus.mode) begin
            state_r <= DISPLAY;
          end else if (weight_s == 3'd1) begin
            // A vote at saturation still locks out and acknowledges.
            if (tally_r[index_s] != CNT_MAX) begin
              tally_r[index_s] <= tally_r[index_s] + CNT_ONE;
            end
            leds_r     <= bus.vote_in;
            busy_r     <= 1'b1;
            lock_cnt_r <= 32'd0;
            state_r    <= LOCK;
          end else if (weight_s >= 3'd2) begin
            invalid_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        LOCK: begin
          vote_count_r <= CNT_ZERO;
          if (lock_cnt_r >= LOCK_LAST) begin
            lock_cnt_r <= 32'd0;
            leds_r     <= 4'b0000;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end else begin
            lock_cnt_r <= lock_cnt_r + 32'd1;
          end
        end
        DISPLAY: begin
          if (!bus.mode) begin
            vote_count_r <= CNT_ZERO;
            state_r      <= IDLE;
          end else begin
            vote_count_r <= tally_r[bus.disp_sel];
          end
        end
        default: begin
          vote_count_r <= CNT_ZERO;
          leds_r       <= 4'b0000;
          busy_r       <= 1'b0;
          lock_cnt_r   <= 32'd0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign bus.vote_count   = vote_count_r;
  assign bus.leds         = leds_r;
  assign bus.busy         = busy_r;
  assign bus.invalid_vote = invalid_r;

`ifdef TOTAL_COUNT_EN
  logic [COUNT_W+1:0] total_r;

  // Running total follows the tallies one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      total_r <= {(COUNT_W+2){1'b0}};
    end else begin
      total_r <= {2'b00, tally_r[0]} + {2'b00, tally_r[1]}
               + {2'b00, tally_r[2]} + {2'b00, tally_r[3]};
    end
  end

  assign bus.total_count = total_r;
`endif

endmodule

// File: tb/tb_vote_tally.sv
// Directed bench for vote_tally (COUNT_W=2, LOCKOUT_CYCLES=4); tallies are
// observed through display mode.
module tb_vote_tally;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  vote_tally_if #(.COUNT_W(2)) bus ();

  vote_tally #(.COUNT_W(2), .LOCKOUT_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single vote from IDLE, then ride out the 4-cycle lockout.
  task automatic do_vote(input logic [3:0] v, input string tag);
    bus.vote_in = v;
    step();
    bus.vote_in = 4'b0000;
    chk({tag, "_leds"}, {28'd0, bus.leds}, {28'd0, v});
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    repeat (4) step();
    chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  // Enter DISPLAY, select a candidate, compare, and return to IDLE.
  task automatic read_tally(input logic [1:0] idx, input logic [1:0] exp, input string tag);
    bus.mode     = 1'b1;
    bus.disp_sel = idx;
    step();
    step();
    chk(tag, {30'd0, bus.vote_count}, {30'd0, exp});
    bus.mode = 1'b0;
    step();
  endtask

  initial begin
    bus.mode     = 1'b0;
    bus.vote_in  = 4'b0000;
    bus.disp_sel = 2'd0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_leds", {28'd0, bus.leds}, 32'd0);
    chk("rst_invalid", {31'd0, bus.invalid_vote}, 32'd0);
    chk("rst_count", {30'd0, bus.vote_count}, 32'd0);

    // Vote for candidate 1; a stray vote during lockout must be ignored.
    bus.vote_in = 4'b0010;
    step();
    bus.vote_in = 4'b0000;
    chk("lock1_busy", {31'd0, bus.busy}, 32'd1);
    chk("lock1_leds", {28'd0, bus.leds}, 32'h2);
    for (int i = 1; i < 4; i++) begin
      bus.vote_in = (i == 1) ? 4'b0100 : 4'b0000;
      step();
      bus.vote_in = 4'b0000;
      chk("lock_busy", {31'd0, bus.busy}, 32'd1);
      chk("lock_leds", {28'd0, bus.leds}, 32'h2);
      chk("lock_invalid", {31'd0, bus.invalid_vote}, 32'd0);
    end
    step();
    chk("unlock_busy", {31'd0, bus.busy}, 32'd0);
    chk("unlock_leds", {28'd0, bus.leds}, 32'd0);
    read_tally(2'd1, 2'd1, "tally1_after_vote");
    read_tally(2'd2, 2'd0, "tally2_ignored");

    // Multi-candidate vote is rejected.
    bus.vote_in = 4'b1001;
    step();
    bus.vote_in = 4'b0000;
    chk("inv_pulse", {31'd0, bus.invalid_vote}, 32'd1);
    chk("inv_busy", {31'd0, bus.busy}, 32'd0);
    chk("inv_leds", {28'd0, bus.leds}, 32'd0);
    step();
    chk("inv_one_cycle", {31'd0, bus.invalid_vote}, 32'd0);
    read_tally(2'd0, 2'd0, "inv_tally0");
    read_tally(2'd3, 2'd0, "inv_tally3");

    // Four votes for candidate 0 saturate a 2-bit counter.
    for (int i = 0; i < 4; i++) do_vote(4'b0001, "sat_vote");
    read_tally(2'd0, 2'd3, "sat_tally0");
`ifdef TOTAL_COUNT_EN
    chk("total_4", {28'd0, bus.total_count}, 32'd4);
`endif

    // Three votes for candidate 3, then browse in display mode.
    for (int i = 0; i < 3; i++) do_vote(4'b1000, "c3_vote");
    bus.mode     = 1'b1;
    bus.vote_in  = 4'b0100;
    bus.disp_sel = 2'd3;
    step();
    chk("disp_entry", {30'd0, bus.vote_count}, 32'd0);
    chk("disp_no_lock", {31'd0, bus.busy}, 32'd0);
    step();
    chk("disp_c3", {30'd0, bus.vote_count}, 32'd3);
    bus.disp_sel = 2'd2;
    step();
    bus.vote_in = 4'b0000;
    chk("disp_c2", {30'd0, bus.vote_count}, 32'd0);
    chk("disp_no_inv", {31'd0, bus.invalid_vote}, 32'd0);
    bus.disp_sel = 2'd1;
    step();
    chk("disp_c1", {30'd0, bus.vote_count}, 32'd1);
    bus.mode = 1'b0;
    step();
    chk("disp_exit", {30'd0, bus.vote_count}, 32'd0);
`ifdef TOTAL_COUNT_EN
    chk("total_7", {28'd0, bus.total_count}, 32'd7);
`endif

    // Mode change during lockout neither shortens it nor enters DISPLAY early.
    bus.vote_in = 4'b0100;
    step();
    bus.vote_in  = 4'b0000;
    bus.mode     = 1'b1;
    bus.disp_sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mode_lock_busy", {31'd0, bus.busy}, 32'd1);
      chk("mode_lock_count", {30'd0, bus.vote_count}, 32'd0);
    end
    step();
    chk("mode_lock_end", {31'd0, bus.busy}, 32'd0);
    step();
    step();
    chk("mode_disp_c2", {30'd0, bus.vote_count}, 32'd1);
    bus.mode = 1'b0;
    step();

    // Reset on the second lockout cycle beats a simultaneous vote.
    bus.vote_in = 4'b1000;
    step();
    bus.vote_in = 4'b0000;
    step();
    reset       = 1'b1;
    bus.vote_in = 4'b0001;
    step();
    reset       = 1'b0;
    bus.vote_in = 4'b0000;
    chk("rst_lock_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_lock_leds", {28'd0, bus.leds}, 32'd0);
`ifdef TOTAL_COUNT_EN
    chk("rst_total", {28'd0, bus.total_count}, 32'd0);
`endif
    step();
    chk("rst_no_relock", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 4; i++) read_tally(2'(i), 2'd0, "rst_tally");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
